// File: rtl/gptp_tx_framer_pkg.sv
// Shared types and constants for the gPTP Ethernet framer and timestamp adder.
package gptp_pkg;

    localparam int unsigned HDR_BYTES   = 14;
    localparam int unsigned MSG_BYTES   = 44;
    localparam int unsigned FRAME_BYTES = 60;
    localparam int unsigned MSG_W       = 8 * MSG_BYTES;
    localparam int unsigned HDR_W       = 8 * HDR_BYTES;
    localparam int unsigned SEC_W       = 48;
    localparam int unsigned NS_W        = 32;
    localparam int unsigned TS_W        = SEC_W + NS_W;
    localparam int unsigned CNT_W       = 6;

    localparam logic [15:0]     PTP_ETHERTYPE = 16'h88F7;
    localparam logic [47:0]     PTP_DST_MAC   = 48'h0180_C200_000E;
    localparam logic [NS_W-1:0] NS_PER_SEC    = 32'd1_000_000_000;

    typedef struct packed {
        logic [SEC_W-1:0] sec;
        logic [NS_W-1:0]  ns;
    } ts_t;

    typedef enum logic [1:0] {IDLE, SEND, DONE} state_e;

    // Byte idx of the on-wire frame: header, then message, then zero pad.
    function automatic logic [7:0] frame_byte(input logic [CNT_W-1:0] idx,
                                              input logic [MSG_W-1:0] msg,
                                              input logic [47:0]      src_mac);
        logic [HDR_W-1:0] hdr;
        int unsigned      i;
        hdr        = {PTP_DST_MAC, src_mac, PTP_ETHERTYPE};
        i          = 32'(idx);
        frame_byte = 8'h00;
        if (i < HDR_BYTES) begin
            frame_byte = hdr[8*(HDR_BYTES-1-i) +: 8];
        end else if (i < HDR_BYTES + MSG_BYTES) begin
            frame_byte = msg[8*(HDR_BYTES+MSG_BYTES-1-i) +: 8];
        end
    endfunction

endpackage

// File: rtl/gptp_tx_framer_if.sv
// Message-in, byte-stream-out and timestamp-return signals of the gPTP framer.
interface gptp_tx_framer_if;
    import gptp_pkg::*;

    logic             gptp_ts_vaild;
    logic             gptp_ts_ready;
    logic [MSG_W-1:0] gptp_ts_data;
    logic [7:0]       tx_tdata;
    logic             tx_tvalid;
    logic             tx_tready;
    logic             tx_tlast;
    logic             gptp_ts_rv_vaild;
    logic [TS_W-1:0]  gptp_ts_rv_data;

    modport master (
        output gptp_ts_vaild, gptp_ts_data, tx_tready,
        input  gptp_ts_ready, tx_tdata, tx_tvalid, tx_tlast,
               gptp_ts_rv_vaild, gptp_ts_rv_data
    );

    modport slave (
        input  gptp_ts_vaild, gptp_ts_data, tx_tready,
        output gptp_ts_ready, tx_tdata, tx_tvalid, tx_tlast,
               gptp_ts_rv_vaild, gptp_ts_rv_data
    );
endinterface

// File: rtl/gptp_ts_add.sv
// Combinational {sec, ns} + ns adder with ns normalisation and 48-bit second wrap.
module gptp_ts_add
    import gptp_pkg::*;
(
    input  ts_t             ts_i,
    input  logic [NS_W-1:0] add_ns_i,
    output ts_t             sum_c_o
);

    logic [NS_W:0] ns_sum;

    // Both operands are below one second, so at most one carry is needed.
    always_comb begin
        ns_sum  = {1'b0, ts_i.ns} + {1'b0, add_ns_i};
        sum_c_o = ts_i;
        if (ns_sum >= {1'b0, NS_PER_SEC}) begin
            sum_c_o.ns  = NS_W'(ns_sum - {1'b0, NS_PER_SEC});
            sum_c_o.sec = ts_i.sec + SEC_W'(1);
        end else begin
            sum_c_o.ns  = ns_sum[NS_W-1:0];
        end
    end

endmodule

// File: rtl/gptp_tx_framer.sv
// Wraps a 44-byte PTP message in an Ethernet header, pads to 60 bytes, streams it
// bytewise and returns the latency-adjusted egress timestamp of byte 0.
module gptp_tx_framer
    import gptp_pkg::*;
#(
    parameter logic [47:0]     SRC_MAC   = 48'h0200_0000_0001,
    parameter logic [NS_W-1:0] TX_LAT_NS = 32'd64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [TS_W-1:0] rtc_time,
    output logic            busy,
    gptp_tx_framer_if.slave bus
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_BYTES - 1);

    state_e           state_q,    state_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [MSG_W-1:0] buf_q,      buf_d;
    ts_t              ts_raw_q,   ts_raw_d;
    ts_t              rv_data_q,  rv_data_d;
    logic             rv_vaild_q, rv_vaild_d;
    logic             ready_q,    ready_d;
    logic             tvalid_q,   tvalid_d;
    logic             tlast_q,    tlast_d;
    logic [7:0]       tdata_q,    tdata_d;
    logic             busy_q,     busy_d;
    ts_t              ts_adj_c;

    gptp_ts_add u_ts_add (
        .ts_i     (ts_raw_q),
        .add_ns_i (TX_LAT_NS),
        .sum_c_o  (ts_adj_c)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            buf_q      <= '0;
            ts_raw_q   <= '0;
            rv_data_q  <= '0;
            rv_vaild_q <= 1'b0;
            ready_q    <= 1'b0;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            tdata_q    <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            buf_q      <= buf_d;
            ts_raw_q   <= ts_raw_d;
            rv_data_q  <= rv_data_d;
            rv_vaild_q <= rv_vaild_d;
            ready_q    <= ready_d;
            tvalid_q   <= tvalid_d;
            tlast_q    <= tlast_d;
            tdata_q    <= tdata_d;
            busy_q     <= busy_d;
        end
    end

    // Outputs are computed from the next state so every port comes straight off a flop.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        buf_d      = buf_q;
        ts_raw_d   = ts_raw_q;
        rv_data_d  = rv_data_q;
        rv_vaild_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.gptp_ts_vaild && ready_q) begin
                    buf_d   = bus.gptp_ts_data;
                    cnt_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (bus.tx_tready) begin
                    if (cnt_q == '0) begin
                        ts_raw_d = ts_t'(rtc_time);
                    end
                    if (cnt_q == LAST_IDX) begin
                        state_d    = DONE;
                        rv_vaild_d = 1'b1;
                        rv_data_d  = ts_adj_c;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        ready_d  = (state_d == IDLE);
        busy_d   = (state_d != IDLE);
        tvalid_d = (state_d == SEND);
        tlast_d  = tvalid_d && (cnt_d == LAST_IDX);
        tdata_d  = tvalid_d ? frame_byte(cnt_d, buf_d, SRC_MAC) : 8'h00;
    end

    assign bus.gptp_ts_ready    = ready_q;
    assign bus.tx_tdata         = tdata_q;
    assign bus.tx_tvalid        = tvalid_q;
    assign bus.tx_tlast         = tlast_q;
    assign bus.gptp_ts_rv_vaild = rv_vaild_q;
    assign bus.gptp_ts_rv_data  = rv_data_q;
    assign busy                 = busy_q;

endmodule

// File: doc/gptp_tx_framer.md
Name: gptp_tx_framer

Overview:
Downstream neighbour of the gPTP tx block. It consumes the 352-bit (44-byte) PTP message that block emits on gptp_ts_vaild/ready/data and prepends a 14-byte Ethernet header (01-80-C2-00-00-0E, SRC_MAC, EtherType 0x88F7). It pads the frame to the 60-byte minimum and streams it bytewise to the MAC. It captures the egress timestamp from the RTC on the first-byte handshake and returns it on gptp_ts_rv_vaild/data.

Parameters:
SRC_MAC, 48'h0200_0000_0001, source MAC inserted at bytes 6..11
TX_LAT_NS, 32'd64, fixed PHY egress latency added to captured ns; must be < 1_000_000_000

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
gptp_ts_vaild  in  1  PTP message valid from tx block
gptp_ts_ready  out  1  framer can accept a message
gptp_ts_data  in  352  PTP message; [351:344] = message byte 0, sent first
rtc_time  in  80  free-running RTC {sec[79:32], ns[31:0]}, ns < 1e9
tx_tdata  out  8  frame byte to MAC
tx_tvalid  out  1  byte valid
tx_tready  in  1  MAC accepts byte
tx_tlast  out  1  last byte of frame (byte 59)
gptp_ts_rv_vaild  out  1  one-cycle pulse: egress timestamp valid
gptp_ts_rv_data  out  80  egress timestamp {sec, ns}
busy  out  1  frame in progress (state != IDLE)

Behaviour:
- Reset (asynchronous, active-high): state IDLE, byte_cnt 0, all outputs 0. gptp_ts_ready is held 0 while reset is high and is 1 from the first clk after release.
- FSM states:
  - IDLE: gptp_ts_ready=1. On vaild&ready, latch gptp_ts_data into the 352-bit buffer, set byte_cnt=0, go to SEND.
  - SEND: tx_tvalid=1. tx_tdata is header byte 0..13, then buffer bytes 14..57, then 8'h00 pad for bytes 58..59. byte_cnt increments only on tvalid&tready. tx_tlast=1 exactly when byte_cnt=59. Handshake on byte 59 goes to DONE.
  - DONE: gptp_ts_rv_vaild=1 for exactly one cycle with the adjusted timestamp, then go to IDLE.
- Latency:
  - Message accepted in cycle N.
  - Byte 0 is valid in cycle N+1.
  - With tready held high, byte 59 is in cycle N+60 and the rv pulse is in cycle N+61.
  - gptp_ts_ready is high again in cycle N+62.
- Backpressure: when tready=0, tdata/tvalid/tlast hold stable and byte_cnt holds. No bytes are skipped or repeated.
- Timestamp capture: rtc_time is sampled in the cycle byte 0 handshakes, not when it is first presented. Adjustment:
  - ns' = ns + TX_LAT_NS.
  - If ns' >= 1_000_000_000: ns' -= 1e9 and sec += 1, with sec wrapping modulo 2^48.
  - The result is registered by the DONE cycle.
- gptp_ts_vaild while busy is ignored (ready=0); the upstream holds its data.
- gptp_ts_data is don't-care after acceptance; the buffer is private.
- Reset mid-frame: the frame is truncated without tlast and no rv pulse is issued. The MAC discards incomplete frames.
- gptp_ts_rv_data holds its last value between pulses.

Decomposition:
- Package gptp_pkg:
  - PTP_ETHERTYPE=16'h88F7
  - PTP_DST_MAC=48'h0180_C200_000E
  - NS_PER_SEC=32'd1_000_000_000
  - HDR_BYTES=14, MSG_BYTES=44, FRAME_BYTES=60
  - state enum {IDLE, SEND, DONE}
  - 80-bit timestamp typedef
- Sub-module gptp_ts_add: combinational 80-bit timestamp + 32-bit ns adder with ns normalisation and 48-bit second carry. It is reused by the rx side.

Test Plan:
- Basic frame: message bytes 0x00..0x2B, tready=1.
  - Required: 60 bytes out in order 01 80 C2 00 00 0E 02 00 00 00 00 01 88 F7 00 01 .. 2B 00 00.
  - tlast only on byte 59; rv pulse one cycle later.
- Timestamp wrap: rtc_time={48'h123456789abc, 32'd999_999_980} at the byte-0 handshake, TX_LAT_NS=64.
  - Required: gptp_ts_rv_data={48'h123456789abd, 32'd44}.
  - Second wrap: rtc_time={48'hFFFFFFFFFFFF, 32'd999_999_999} gives {48'h0, 32'd63}.
- Backpressure:
  - tready low for 5 cycles before byte 0, with the RTC advancing 1 ns per cycle: the captured ns equals the RTC value at the actual handshake, plus 64.
  - tready toggling 1/0 through the frame: the byte stream is identical to the basic frame.
- Busy rejection: assert gptp_ts_vaild continuously for two messages A and B.
  - Required: B accepted only in the cycle after A's rv pulse (gptp_ts_ready=0 throughout A).
  - Frame B carries B's bytes.
- Reset mid-frame: assert reset at byte 30.
  - Required: tvalid, tlast and rv_vaild drop to 0 immediately, with no rv pulse.
  - gptp_ts_ready=1 one cycle after release; the next message produces a complete, correct frame.
